// File: rtl/life_gen_controller.sv
// Game of Life generation sequencer: owns the N x N board, paces generations and
// steps one row per cycle into a shadow buffer. Define LIFE_TORUS_EN for a wrapped board.
module life_gen_controller #(
    parameter int unsigned N             = 8,
    parameter int unsigned TICKS_PER_GEN = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 step_req,
    input  logic                 seed_wr,
    input  logic [$clog2(N)-1:0] seed_addr,
    input  logic [N-1:0]         seed_data,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [N-1:0]         rd_data,
    output logic                 busy,
    output logic                 gen_done,
    output logic [15:0]          generation
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned TW = $clog2(TICKS_PER_GEN + 1);
`ifdef LIFE_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, COMPUTE, COMMIT} state_t;

    state_t         state, state_d;
    logic [TW-1:0]  tick, tick_d;
    logic [AW-1:0]  row, row_d;
    logic           compute_en;
    logic           commit_en;
    logic           busy_d;

    logic [N-1:0]   cur  [N];
    logic [N-1:0]   nxt  [N];
    logic [N-1:0]   row_up;
    logic [N-1:0]   row_dn;
    logic [N-1:0]   new_row;

    // Applies the life rule to one row given its vertical neighbours.
    function automatic logic [N-1:0] life_row(input logic [N-1:0] up,
                                              input logic [N-1:0] mid,
                                              input logic [N-1:0] dn);
        logic [N+1:0] eu, em, ed;
        logic [3:0]   cnt;
        logic [N-1:0] res;
        eu  = TORUS ? {up[0], up, up[N-1]}    : {1'b0, up, 1'b0};
        em  = TORUS ? {mid[0], mid, mid[N-1]} : {1'b0, mid, 1'b0};
        ed  = TORUS ? {dn[0], dn, dn[N-1]}    : {1'b0, dn, 1'b0};
        res = '0;
        for (int c = 0; c < N; c++) begin
            cnt = 4'(eu[c]) + 4'(eu[c+1]) + 4'(eu[c+2])
                + 4'(em[c])               + 4'(em[c+2])
                + 4'(ed[c]) + 4'(ed[c+1]) + 4'(ed[c+2]);
            res[c] = (cnt == 4'd3) || (em[c+1] && (cnt == 4'd2));
        end
        return res;
    endfunction

    always_comb begin
        row_up  = (row == '0) ? (TORUS ? cur[N-1] : '0) : cur[row - 1'b1];
        row_dn  = (row == AW'(N - 1)) ? (TORUS ? cur[0] : '0) : cur[row + 1'b1];
        new_row = life_row(row_up, cur[row], row_dn);
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state;
        tick_d     = tick;
        row_d      = row;
        compute_en = 1'b0;
        commit_en  = 1'b0;
        case (state)
            IDLE: begin
                tick_d = '0;
                row_d  = '0;
                if (step_req) begin
                    state_d = COMPUTE;
                end else if (ena) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (step_req) begin
                    state_d = COMPUTE;
                    tick_d  = '0;
                end else if (!ena) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (tick == TW'(TICKS_PER_GEN - 1)) begin
                    state_d = COMPUTE;
                    tick_d  = '0;
                end else begin
                    tick_d = tick + 1'b1;
                end
            end
            COMPUTE: begin
                compute_en = 1'b1;
                if (row == AW'(N - 1)) begin
                    row_d   = '0;
                    state_d = COMMIT;
                end else begin
                    row_d = row + 1'b1;
                end
            end
            COMMIT: begin
                commit_en = 1'b1;
                tick_d    = '0;
                state_d   = ena ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == COMPUTE) || (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            row      <= '0;
            busy     <= 1'b0;
            gen_done <= 1'b0;
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            row      <= row_d;
            busy     <= busy_d;
            gen_done <= commit_en;
        end
    end

    // Board storage, shadow buffer and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                cur[r] <= '0;
                nxt[r] <= '0;
            end
            generation <= '0;
            rd_data    <= '0;
        end else begin
            rd_data <= cur[rd_addr];
            if (seed_wr && ((state == IDLE) || (state == WAIT))) begin
                cur[seed_addr] <= seed_data;
            end
            if (compute_en) begin
                nxt[row] <= new_row;
            end
            if (commit_en) begin
                for (int r = 0; r < N; r++) begin
                    cur[r] <= nxt[r];
                end
                generation <= generation + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_life_gen_controller.sv
// Self-checking bench for life_gen_controller against a cell-by-cell reference board.
module tb_life_gen_controller;

    localparam int N     = 8;
    localparam int TICKS = 5;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         step_req;
    logic         seed_wr;
    logic [2:0]   seed_addr;
    logic [7:0]   seed_data;
    logic [2:0]   rd_addr;
    logic [7:0]   rd_data;
    logic         busy;
    logic         gen_done;
    logic [15:0]  generation;

    int           checks;
    int           errors;
    logic [7:0]   model [N];
    logic [15:0]  exp_gen;

    life_gen_controller #(.N(N), .TICKS_PER_GEN(TICKS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .step_req   (step_req),
        .seed_wr    (seed_wr),
        .seed_addr  (seed_addr),
        .seed_data  (seed_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .gen_done   (gen_done),
        .generation (generation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference generation: count the 8 neighbours of every cell directly.
    task automatic model_step();
        logic [7:0] nb [N];
        int cnt, rr, cc;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_TORUS_EN
                            rr = (rr + N) % N;
                            cc = (cc + N) % N;
                            cnt += int'(model[rr][cc]);
`else
                            if (rr >= 0 && rr < N && cc >= 0 && cc < N)
                                cnt += int'(model[rr][cc]);
`endif
                        end
                    end
                end
                nb[r][c] = (cnt == 3) || (model[r][c] && cnt == 2);
            end
        end
        for (int r = 0; r < N; r++) model[r] = nb[r];
    endtask

    task automatic set_row(input int r, input logic [7:0] d);
        seed_wr   = 1'b1;
        seed_addr = 3'(r);
        seed_data = d;
        cyc(1);
        seed_wr   = 1'b0;
        model[r]  = d;
    endtask

    task automatic clear_board();
        for (int r = 0; r < N; r++) set_row(r, 8'h00);
    endtask

    task automatic read_row(input int r, output logic [7:0] d);
        rd_addr = 3'(r);
        cyc(1);
        d = rd_data;
    endtask

    task automatic check_board(input string tag);
        logic [7:0] d;
        for (int r = 0; r < N; r++) begin
            read_row(r, d);
            check($sformatf("%s_row%0d", tag, r), 32'(d), 32'(model[r]));
        end
    endtask

    // Single step from IDLE; optionally tries to seed row 0 mid-compute.
    task automatic do_step(input bit seed_busy);
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        check("step_busy", 32'(busy), 32'd1);
        if (seed_busy) begin
            cyc(2);
            seed_wr   = 1'b1;
            seed_addr = 3'd0;
            seed_data = 8'hFF;
            cyc(2);
            seed_wr   = 1'b0;
            cyc(N + 1 - 4);
        end else begin
            cyc(N + 1);
        end
        model_step();
        exp_gen++;
        check("step_gen_done", 32'(gen_done), 32'd1);
        check("step_idle", 32'(busy), 32'd0);
        check("step_generation", 32'(generation), 32'(exp_gen));
        cyc(1);
        check("step_gen_done_pulse", 32'(gen_done), 32'd0);
    endtask

    task automatic wait_gen_done(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!gen_done && n < 200);
        check("gen_done_seen", 32'(gen_done), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int pulses;
        checks    = 0;
        errors    = 0;
        exp_gen   = '0;
        rst       = 1'b1;
        ena       = 1'b0;
        step_req  = 1'b0;
        seed_wr   = 1'b0;
        seed_addr = '0;
        seed_data = '0;
        rd_addr   = '0;
        for (int r = 0; r < N; r++) model[r] = 8'h00;

        // Reset
        cyc(2);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_generation", 32'(generation), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (gen_done) pulses++;
        end
        check("rst_no_gen_done", 32'(pulses), 32'd0);
        check_board("rst");

        // Seed and read the same row on one edge: old value first
        rd_addr   = 3'd5;
        seed_wr   = 1'b1;
        seed_addr = 3'd5;
        seed_data = 8'hA5;
        cyc(1);
        seed_wr   = 1'b0;
        check("seed_rd_old", 32'(rd_data), 32'h00);
        cyc(1);
        check("seed_rd_new", 32'(rd_data), 32'hA5);
        model[5] = 8'hA5;
        set_row(5, 8'h00);

        // Blinker
        set_row(3, 8'b0001_1100);
        do_step(1'b0);
        check_board("blink1");
        read_row(2, d);
        check("blink_row2", 32'(d), 32'h08);
        do_step(1'b0);
        check_board("blink2");
        read_row(3, d);
        check("blink_restored", 32'(d), 32'h1C);

        // Free-run with a still-life block
        clear_board();
        set_row(1, 8'b0000_0110);
        set_row(2, 8'b0000_0110);
        ena = 1'b1;
        wait_gen_done(n);
        model_step();
        exp_gen++;
        check("free_gen1", 32'(generation), 32'(exp_gen));
        for (int i = 0; i < 2; i++) begin
            wait_gen_done(n);
            model_step();
            exp_gen++;
            check("free_period", 32'(n), 32'(TICKS + N + 1));
            check("free_gen", 32'(generation), 32'(exp_gen));
        end
        n = 0;
        while (!busy && n < 50) begin
            cyc(1);
            n++;
        end
        check("free_busy_seen", 32'(busy), 32'd1);
        cyc(3);
        ena = 1'b0;
        wait_gen_done(n);
        model_step();
        exp_gen++;
        check("drop_ena_gen", 32'(generation), 32'(exp_gen));
        pulses = 0;
        for (int i = 0; i < 3 * TICKS; i++) begin
            cyc(1);
            if (gen_done || busy) pulses++;
        end
        check("drop_ena_idle", 32'(pulses), 32'd0);
        check_board("block");

        // Seed attempt during compute is dropped
        do_step(1'b1);
        check_board("seed_busy");
        read_row(0, d);
        check("seed_busy_row0", 32'(d), 32'h00);

        // Horizontal blinker on the top edge
        clear_board();
        set_row(0, 8'b0011_1000);
        do_step(1'b0);
        check_board("edge");
        read_row(1, d);
        check("edge_row1", 32'(d), 32'h10);
        read_row(7, d);
`ifdef LIFE_TORUS_EN
        check("edge_row7", 32'(d), 32'h10);
`else
        check("edge_row7", 32'(d), 32'h00);
`endif

        // Random boards, random step counts
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < N; r++) set_row(r, 8'($urandom));
            n = int'($urandom_range(1, 3));
            for (int s = 0; s < n; s++) begin
                do_step(1'b0);
                check_board($sformatf("rand%0d_%0d", it, s));
            end
        end

        // Reset partway through a compute
        for (int r = 0; r < N; r++) set_row(r, 8'($urandom));
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int r = 0; r < N; r++) model[r] = 8'h00;
        exp_gen = '0;
        pulses = 0;
        for (int i = 0; i < N + 4; i++) begin
            cyc(1);
            if (gen_done) pulses++;
        end
        check("midrst_no_gen_done", 32'(pulses), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_generation", 32'(generation), 32'(exp_gen));
        check_board("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_gen_controller.md
# life_gen_controller

Sequencer for the Game of Life board: holds the N×N cell board, paces generations with a tick counter, and steps the board one row per cycle into a shadow buffer before committing it atomically. It sits between `main`'s seeding and display logic and the LED outputs. All other logic reads cells only through its registered read port.

## Interface

**Parameters**
- `N`, default 8: board width and height in cells; must be ≥ 3.
- `TICKS_PER_GEN`, default 1000: `WAIT` cycles between generations; must be ≥ 1.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ena`, in, 1: run enable, level.
- `step_req`, in, 1: single-step request, one-cycle pulse.
- `seed_wr`, in, 1: seed write strobe.
- `seed_addr`, in, $clog2(N): seed row index.
- `seed_data`, in, N: seed row value; bit c is column c; 1 = alive.
- `rd_addr`, in, $clog2(N): display row index.
- `rd_data`, out, N: registered committed row, available 1 cycle after `rd_addr`.
- `busy`, out, 1: high in `COMPUTE` and `COMMIT`.
- `gen_done`, out, 1: one-cycle pulse, asserted with the new board.
- `generation`, out, 16: committed generation count; wraps at 2^16.

## Operation

**State machine:** `IDLE`, `WAIT`, `COMPUTE`, `COMMIT`.
- `IDLE`:
  - `ena`=1 → `WAIT`, with the tick counter cleared.
  - `step_req`=1 → `COMPUTE`; this wins over `ena`.
- `WAIT`:
  - The tick counter increments each cycle.
  - At count `TICKS_PER_GEN`-1 → `COMPUTE`.
  - `step_req` → `COMPUTE` immediately.
  - `ena`=0 (without `step_req`) → `IDLE`, counter cleared.
- `COMPUTE`:
  - The row counter runs 0..N-1; each cycle, `next[r]` is computed from `cur[r-1]`, `cur[r]` and `cur[r+1]`.
  - After row N-1 → `COMMIT`.
  - Deasserting `ena` does not abort; `step_req` is ignored.
- `COMMIT`:
  - `cur` ← `next` for all rows, `generation` += 1, `gen_done` ← 1.
  - → `WAIT` (tick counter cleared) if `ena`=1, else → `IDLE`.

**Cell rule**
- A live cell stays alive with 2 or 3 live neighbours.
- A dead cell becomes alive with exactly 3.
- Every other case gives a dead cell.
- Neighbour count uses the 8-neighbourhood, 4-bit sum, with edge handling per Configuration.

**Seeding**
- A `seed_wr` in `IDLE` or `WAIT` writes `cur[seed_addr]` ← `seed_data` on that edge.
- A `seed_wr` while `busy`=1 is silently dropped.
- Seeding does not change `generation`.

**Read port**
- `rd_data` ← `cur[rd_addr]` every edge, in every state.
- It shows only committed data; `next` is never visible.
- During `COMPUTE` it shows the pre-step board.

## Timing

**Reset values**
- `cur` and `next` = all zero.
- State `IDLE`; tick and row counters = 0.
- `rd_data` = 0, `busy` = 0, `gen_done` = 0, `generation` = 0.
- Reset mid-`COMPUTE` discards the partial step.

**Latencies**
- `step_req` in `IDLE` sampled at edge t: `busy` = 1 from t, rows computed at edges t+1..t+N, commit at edge t+N+1.
- The cycle after t+N+1: `gen_done` = 1, `busy` = 0, new `generation` visible, `rd_data` reflects the new board after one further edge.
- Free-running period: `TICKS_PER_GEN` + N + 1 cycles per generation.
- `seed_wr` and a `rd_addr` for the same row on the same edge: `rd_data` shows the old value; the new value appears on the next edge.

## Configuration

- `LIFE_TORUS_EN` defined:
  - Board is toroidal: row -1 ≡ N-1, row N ≡ 0.
  - Columns wrap the same way.
- `LIFE_TORUS_EN` undefined:
  - Cells outside the board count as dead.
  - No wrap.

## Test plan

1. **Reset:** assert `rst` 2 cycles, then release.
   - Every `rd_addr` gives `rd_data` = 0.
   - `busy` = 0, `generation` = 0, `gen_done` never pulses with `ena` = 0.
2. **Blinker, N = 8:**
   - Seed `cur[3]` = 8'b0001_1100, then `step_req`.
   - After N+2 cycles: rows 2, 3, 4 = 8'b0000_1000; `generation` = 1.
   - Second step restores the original board.
3. **Free-run timing, `TICKS_PER_GEN` = 5:**
   - Seed a 2×2 block at rows 1–2, cols 1–2, then set `ena` = 1.
   - `gen_done` pulses every 14 cycles and the board stays unchanged.
   - Drop `ena` mid-`COMPUTE`: that generation completes, then the block returns to `IDLE`.
4. **Seed while busy:** `seed_wr` to row 0 with 8'hFF during `COMPUTE` → row 0 is unaffected after commit.
5. **Edges:** seed a horizontal blinker on row 0, cols 3–5, and step once.
   - With `LIFE_TORUS_EN`: rows 7, 0, 1 = 8'b0001_0000.
   - Without: rows 0 and 1 = 8'b0001_0000, row 7 = 0.
6. **Reset mid-`COMPUTE`:** assert `rst` on row 4 → board all zero, `generation` = 0, no `gen_done`.
